// File: rtl/mux_pkg.sv
// Shared types and sizes for the 16:1 mux datapath and its serializer wrapper.
package mux_pkg;

    localparam int SEL_W  = 4;
    localparam int DATA_W = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/mux16to1.sv
// 16:1 bit mux: q is the data bit picked by select.
module mux16to1
    import mux_pkg::*;
(
    input  logic [SEL_W-1:0]  select,
    input  logic [DATA_W-1:0] d,
    output logic              q
);

    assign q = d[select];

endmodule

// File: rtl/mux_serializer16.sv
// Parallel-to-serial stage: holds a 16-bit word and walks the mux select across it,
// one bit per serial handshake, tagging the final bit and counting finished words.
//   state | meaning
//   IDLE  | no word held, ready to load
//   SHIFT | word held, presenting data_reg[sel] on the serial port
module mux_serializer16
    import mux_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel,
    output logic              busy,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
    localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : SEL_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] data_reg;
    logic [DATA_W-1:0] data_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              xfer;
    logic              load;

    assign ser_valid = (state == SHIFT);
    assign busy      = ser_valid;
    assign ser_last  = ser_valid && (sel == SEL_END);
    assign xfer      = ser_valid && ser_ready;
    // Ready on the last transfer lets the next word follow without a bubble.
    assign load_ready = rst_n && ((state == IDLE) || (ser_last && ser_ready));
    assign load       = load_valid && load_ready;

    mux16to1 u_mux (
        .select (sel),
        .d      (data_reg),
        .q      (ser_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= '0;
            sel      <= SEL_START;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            data_reg <= data_nxt;
            sel      <= sel_nxt;
            word_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data_reg;
        sel_nxt   = sel;
        cnt_nxt   = word_cnt;
        if (load) begin
            data_nxt  = load_data;
            sel_nxt   = SEL_START;
            state_nxt = SHIFT;
        end else if (xfer && ser_last) begin
            sel_nxt   = SEL_START;
            state_nxt = IDLE;
        end else if (xfer) begin
            sel_nxt = MSB_FIRST ? (sel - 1'b1) : (sel + 1'b1);
        end
        if (xfer && ser_last) begin
            cnt_nxt = word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_serializer16.sv
// Bench for mux_serializer16: LSB-first, MSB-first and narrow-counter instances
// checked against a bit-order model of the serial stream.
module tb_mux_serializer16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cnt0  = 0;

    logic        lv0, lr0, sb0, sv0, sr0, sl0, busy0;
    logic [15:0] ld0;
    logic [3:0]  sel0;
    logic [7:0]  wc0;

    logic        lv1, lr1, sb1, sv1, sr1, sl1, busy1;
    logic [15:0] ld1;
    logic [3:0]  sel1;
    logic [7:0]  wc1;

    logic        lv2, lr2, sb2, sv2, sr2, sl2, busy2;
    logic [15:0] ld2;
    logic [3:0]  sel2;
    logic [1:0]  wc2;

    mux_serializer16 #(.MSB_FIRST(1'b0), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv0), .load_ready(lr0), .load_data(ld0),
        .ser_bit(sb0), .ser_valid(sv0), .ser_ready(sr0), .ser_last(sl0),
        .sel(sel0), .busy(busy0), .word_cnt(wc0));

    mux_serializer16 #(.MSB_FIRST(1'b1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv1), .load_ready(lr1), .load_data(ld1),
        .ser_bit(sb1), .ser_valid(sv1), .ser_ready(sr1), .ser_last(sl1),
        .sel(sel1), .busy(busy1), .word_cnt(wc1));

    mux_serializer16 #(.MSB_FIRST(1'b0), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv2), .load_ready(lr2), .load_data(ld2),
        .ser_bit(sb2), .ser_valid(sv2), .ser_ready(sr2), .ser_last(sl2),
        .sel(sel2), .busy(busy2), .word_cnt(wc2));

    typedef struct {
        logic [15:0] data;
        bit          rnd;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[4];
    int   exp_wc2[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // k-th bit on the wire for word w
    function automatic logic exp_bit(input logic [15:0] w, input int k, input bit msb);
        return msb ? w[15-k] : w[k];
    endfunction

    // Serialize one word on u0; called at a negedge with u0 idle.
    task automatic serial0(input logic [15:0] w, input bit rnd, input logic [7:0] exp_cnt);
        int          k = 0;
        int          cyc = 0;
        logic [15:0] cap = '0;
        logic        pb = 1'b0;
        logic [3:0]  ps = '0;
        bit          stalled = 1'b0;
        lv0 = 1'b1;
        ld0 = w;
        sr0 = 1'b0;
        #1 check("load_ready_idle", lr0, 1);
        @(negedge clk);
        while (k < 16 && cyc < 400) begin
            sr0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            lv0 = (k < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
            ld0 = 16'($urandom);
            #1;
            check("ser_valid", sv0, 1);
            check("busy", busy0, 1);
            if (stalled) begin
                check("stall_bit", sb0, pb);
                check("stall_sel", sel0, ps);
            end
            check("ser_bit", sb0, exp_bit(w, k, 1'b0));
            check("sel", sel0, k);
            check("ser_last", sl0, k == 15);
            check("load_ready", lr0, (k == 15) && sr0);
            stalled = !sr0;
            pb = sb0;
            ps = sel0;
            if (sr0) begin
                cap = {sb0, cap[15:1]};
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        sr0 = 1'b0;
        lv0 = 1'b0;
        check("xfer_count", k, 16);
        #1;
        check("idle_after", sv0, 0);
        check("word_cnt", wc0, exp_cnt);
        check("capture", cap, w);
    endtask

    initial begin
        vecs[0] = '{16'h0001, 1'b0, 8'd1};
        vecs[1] = '{16'hA5C3, 1'b1, 8'd2};
        vecs[2] = '{16'hFFFE, 1'b1, 8'd3};
        vecs[3] = '{16'h8000, 1'b0, 8'd4};
        exp_wc2 = '{1, 2, 3, 0, 1};

        rst_n = 1'b0;
        lv0 = 1'b0; ld0 = '0; sr0 = 1'b1;
        lv1 = 1'b0; ld1 = '0; sr1 = 1'b0;
        lv2 = 1'b0; ld2 = '0; sr2 = 1'b0;

        @(negedge clk);
        #1;
        check("rst_ser_valid", sv0, 0);
        check("rst_ser_last", sl0, 0);
        check("rst_busy", busy0, 0);
        check("rst_sel", sel0, 0);
        check("rst_word_cnt", wc0, 0);
        check("rst_load_ready", lr0, 0);
        check("rst_sel_msb", sel1, 15);
        rst_n = 1'b1;
        #1 check("load_ready_after_rst", lr0, 1);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            serial0(vecs[i].data, vecs[i].rnd, vecs[i].exp_cnt);
            cnt0++;
        end
        for (int i = 0; i < 6; i++) begin
            cnt0++;
            serial0(16'($urandom), 1'b1, 8'(cnt0));
        end

        // back-to-back FFFF then 0000
        lv0 = 1'b1; ld0 = 16'hFFFF; sr0 = 1'b1;
        @(negedge clk);
        ld0 = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            #1;
            check("b2b_valid", sv0, 1);
            check("b2b_bit", sb0, k < 16);
            check("b2b_last", sl0, (k % 16) == 15);
            check("b2b_load_ready", lr0, (k % 16) == 15);
            @(negedge clk);
            if (k == 15) lv0 = 1'b0;
        end
        cnt0 += 2;
        #1;
        check("b2b_idle", sv0, 0);
        check("b2b_word_cnt", wc0, 8'(cnt0));

        // reset after 7 bits of 1234
        lv0 = 1'b1; ld0 = 16'h1234; sr0 = 1'b1;
        @(negedge clk);
        lv0 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1 check("pre_rst_bit", sb0, exp_bit(16'h1234, k, 1'b0));
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", sv0, 0);
        check("mid_rst_sel", sel0, 0);
        check("mid_rst_word_cnt", wc0, 0);
        check("mid_rst_load_ready", lr0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt0 = 1;
        serial0(16'h0003, 1'b0, 8'd1);

        // MSB-first instance
        @(negedge clk);
        lv1 = 1'b1; ld1 = 16'h8001; sr1 = 1'b1;
        #1;
        check("msb_load_ready", lr1, 1);
        check("msb_idle_sel", sel1, 15);
        @(negedge clk);
        lv1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            #1;
            check("msb_valid", sv1, 1);
            check("msb_bit", sb1, exp_bit(16'h8001, k, 1'b1));
            check("msb_sel", sel1, 15 - k);
            check("msb_last", sl1, k == 15);
            @(negedge clk);
        end
        #1;
        check("msb_idle", sv1, 0);
        check("msb_word_cnt", wc1, 1);
        check("msb_sel_reload", sel1, 15);

        // 2-bit counter instance, load_valid held mid-word with junk data
        for (int i = 0; i < 5; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            @(negedge clk);
            lv2 = 1'b1; ld2 = w; sr2 = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 16; k++) begin
                lv2 = (k < 15);
                ld2 = ~w;
                #1;
                check("cnt2_bit", sb2, exp_bit(w, k, 1'b0));
                check("cnt2_load_ready", lr2, k == 15);
                @(negedge clk);
            end
            lv2 = 1'b0;
            #1;
            check("cnt2_idle", sv2, 0);
            check("cnt2_word_cnt", wc2, exp_wc2[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
